// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared constants, state encoding and bit-mixing helpers for the 24-bit
// SHA-256 core and its message scheduler.
//   K       : 64 round constants
//   H_INIT  : initial hash value, H0 first
//   state_t : IDLE / ROUND / DONE
package sha256_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
// 16-word sliding window of the SHA-256 message schedule for a single
// padded 24-bit message.
//   clk   : clock, rising edge
//   load  : load the padded block (msg, 0x80, zeros, bit length 24)
//   shift : advance the window by one word
//   msg   : 24-bit message, MSB byte first
//   w_cur : W[t] for the round currently executing (window slot 0)
module sha256_msg_sched import sha256_pkg::*; (
  input  logic        clk,
  input  logic        load,
  input  logic        shift,
  input  logic [23:0] msg,
  output logic [31:0] w_cur
);

  logic [31:0] win [0:15];
  logic [31:0] w_new;

  // Window holds W[t..t+15]; the word entering at the top is W[t+16].
  always_comb begin
    w_new = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
  end

  always_ff @(posedge clk) begin
    if (load) begin
      win[0] <= {msg, 8'h80};
      for (int i = 1; i < 15; i++) win[i] <= '0;
      win[15] <= 32'd24;
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_new;
    end
  end

  assign w_cur = win[0];

endmodule

// File: rtl/sha256_24b_core.sv
// sha256_24b_core
// Iterative single-block SHA-256 for 24-bit messages, one round per clock.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   valid   : start request, held for the whole hash; low aborts
//   msg_in  : message, sampled on the accept edge only
//   msg_out : digest, H0 in [255:224] .. H7 in [31:0]
//   ready   : one-cycle done pulse, msg_out valid in the same cycle
module sha256_24b_core import sha256_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [23:0]  msg_in,
  output logic [255:0] msg_out,
  output logic         ready
);

  state_t      state, next_state;
  logic [5:0]  round_cnt;
  logic        armed;
  logic [31:0] wv      [0:7];
  logic [31:0] next_wv [0:7];
  logic [31:0] w_cur, t1, t2;
  logic        accept, do_round, finish;

  sha256_msg_sched u_sched (
    .clk   (clk),
    .load  (accept),
    .shift (do_round),
    .msg   (msg_in),
    .w_cur (w_cur)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // armed blocks a restart while the host still holds valid after a hash.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    do_round   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (valid && armed) begin
          accept     = 1'b1;
          next_state = ROUND;
        end
      end
      ROUND: begin
        if (!valid) begin
          next_state = IDLE;
        end else begin
          do_round = 1'b1;
          if (round_cnt == 6'd63) begin
            finish     = 1'b1;
            next_state = DONE;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One compression round; wv[0..7] are a..h.
  always_comb begin
    t1 = wv[7] + bsig1(wv[4]) + ch(wv[4], wv[5], wv[6]) + K[round_cnt] + w_cur;
    t2 = bsig0(wv[0]) + maj(wv[0], wv[1], wv[2]);
    next_wv[0] = t1 + t2;
    next_wv[1] = wv[0];
    next_wv[2] = wv[1];
    next_wv[3] = wv[2];
    next_wv[4] = wv[3] + t1;
    next_wv[5] = wv[4];
    next_wv[6] = wv[5];
    next_wv[7] = wv[6];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 8; i++) wv[i] <= H_INIT[i];
    end else if (do_round) begin
      for (int i = 0; i < 8; i++) wv[i] <= next_wv[i];
    end
  end

  // The counter wraps 63 -> 0 on the final round; an abort leaves it to be
  // reloaded by the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_cnt <= '0;
      armed     <= 1'b1;
      ready     <= 1'b0;
      msg_out   <= '0;
    end else begin
      ready <= finish;
      if (accept) begin
        armed     <= 1'b0;
        round_cnt <= '0;
      end else if (state == IDLE && !valid) begin
        armed <= 1'b1;
      end
      if (do_round) round_cnt <= round_cnt + 6'd1;
      if (finish) begin
        for (int i = 0; i < 8; i++) msg_out[255 - 32*i -: 32] <= H_INIT[i] + next_wv[i];
      end
    end
  end

endmodule

// File: doc/sha256_24b_core.md
# sha256_24b_core

Single-block SHA-256 engine for 24-bit messages. It sits directly downstream of the SHA APB peripheral, which drives `valid`/`msg_in` and captures `msg_out` on the `ready` pulse. The core pads the 3-byte message internally, runs the 64-round compression iteratively at one round per clock, and returns the 256-bit digest.

## Interface
- No parameters; message width (24) and digest width (256) are fixed by the algorithm.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `valid`  in  1  start request; held high by the host for the whole hash; low aborts.
- `msg_in`  in  24  message bytes, MSB byte first; sampled only on the accept edge.
- `msg_out`  out  256  digest; H0 in [255:224] … H7 in [31:0]; reset 0.
- `ready`  out  1  one-cycle done pulse, registered; `msg_out` is valid in the same cycle; reset 0.

## Operation
- States: IDLE, ROUND, DONE.
- `armed` flag: reset value 1. Cleared on accept. Set in IDLE whenever `valid`=0.
- IDLE:
  - If `valid` & `armed` → accept. Load a..h from H_INIT.
  - Load the W window with W0={msg_in,8'h80}, W1..W14=0, W15=32'd24.
  - Set round counter to 0 and go to ROUND.
- ROUND, counter t=0..63, one round per edge:
  - T1=h+Σ1(e)+Ch(e,f,g)+K[t]+W[t].
  - T2=Σ0(a)+Maj(a,b,c).
  - All additions are mod 2^32.
- W schedule: 16-word shift window.
  - For t≥16: W[t]=σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16].
  - The window shifts every round.
- On round 63:
  - Register `msg_out` ← H_INIT[i] + (a..h after round 63), per word, mod 2^32.
  - Set `ready` ←1 and go to DONE.
- DONE: `ready` ←0 and go to IDLE. This state lasts exactly one cycle.
- `msg_out` holds its value until the next successful completion. It is never cleared by abort.
- Abort: `valid`=0 in ROUND → IDLE next edge. No `ready` pulse and `msg_out` is unchanged.
- `msg_in` changes after the accept edge are ignored.
- `valid` still high after `ready`: no restart. `armed` is clear, so `valid` must be seen low in IDLE for at least one cycle first.

## Timing
- Accept at edge k. Rounds 0..63 execute on edges k+1..k+64.
- `ready` is high for exactly the cycle between edges k+64 and k+65.
  - Latency is 64 clocks from accept to `ready`.
  - Minimum issue interval: 66 clocks (accept, 64 rounds, DONE). Add one low-`valid` IDLE cycle for rearm.
- `rst` is sampled every edge and overrides everything, including mid-ROUND and DONE. The effects take place at the next edge:
  - state → IDLE, counter 0, `armed` 1;
  - `ready` 0, `msg_out` 0.
- `rst` and `valid` high together: reset wins, no accept.
  - If `valid` is still high on the first edge after reset release, accept occurs on that edge.
- Counter wraps only through the round-63 → DONE transition; it never exceeds 63.

## Structure
- Package `sha256_pkg` contains:
  - K[0:63] and H_INIT[0:7] as 32-bit constant arrays;
  - the state enum {IDLE, ROUND, DONE};
  - functions ch, maj, bsig0 (Σ0), bsig1 (Σ1), ssig0 (σ0), ssig1 (σ1).
- One sub-module is natural: `sha256_msg_sched`.
  - Inputs: load, shift, the 24-bit message.
  - Output: current W[t].
  - It owns the 16×32 window.
- Everything else lives in `sha256_24b_core`: FSM, counter, working registers, digest register.

## Test plan
- `msg_in`=0x616263 ("abc"), `valid` held until `ready` → `ready` exactly 64 clocks after accept. `msg_out` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Same run, `msg_in` toggled to 0xFFFFFF on the edge after accept → identical digest.
- `valid` dropped during round 10 → no `ready` pulse. `msg_out` retains the previous "abc" digest. A new `valid` restarts from round 0 with the full 64-clock latency.
- `valid` kept high for 10 cycles after `ready` → no second accept. It is then dropped one cycle and raised with a random 24-bit message → digest matches the software SHA-256 model.
- `rst` pulsed at round 30 → next cycle `msg_out`=0, `ready`=0, IDLE.
  - `valid` high throughout → accept on the first post-reset edge.
  - Correct "abc" digest 64 clocks later.
- 200 random messages issued back-to-back at the minimum rearm interval → every digest matches the model and exactly one `ready` pulse per accept.
